seg_scan_divider: RTL and testbench

Parametrised refresh-clock generator and digit scanner for the multiplexed 7-segment display path. It divides `clk_in` by a runtime-loadable divisor and emits a one-cycle refresh tick plus a toggled `clk_out`. A digit index with an active-low one-hot anode vector advances on every tick. It sits between the board clock and the segment decoder, replacing the fixed-divisor display clock.

---
 rtl/seg_scan_divider.sv | 149 ++++++++++++++
 tb/tb_seg_scan_divider.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_divider.sv
// Refresh-tick divider and active-low digit scanner for the multiplexed 7-segment path.
// Optional anode blanking after each digit change is built when SEG_BLANK_EN is defined.
module seg_scan_divider #(
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 100000,
  parameter int NUM_DIGITS  = 4,
  parameter int DIG_W       = 2,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  en,
  input  logic [CNT_W-1:0]      div_in,
  input  logic                  div_load,
  output logic                  div_pending,
  output logic [CNT_W-1:0]      div_cur,
  output logic                  tick,
  output logic                  clk_out,
  output logic [DIG_W-1:0]      digit_idx,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  blank
);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      div_cur_q, div_cur_d;
  logic [CNT_W-1:0]      shadow_q, shadow_d;
  logic                  pend_q, pend_d;
  logic                  tick_q, tick_d;
  logic                  clk_out_q, clk_out_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;

  logic [CNT_W-1:0] div_clamp;
  logic [DIG_W-1:0] dig_nxt;
  logic             wrap;

  function automatic logic [NUM_DIGITS-1:0] sel_low(input logic [DIG_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

  assign div_clamp = (div_in == '0) ? CNT_W'(1) : div_in;
  assign dig_nxt   = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
  // >= rather than == so a divisor applied below the held count wraps at once
  assign wrap      = en && (cnt_q >= div_cur_q);

`ifdef SEG_BLANK_EN
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    dig_d     = dig_q;
    anode_d   = anode_q;
`ifdef SEG_BLANK_EN
    blank_d   = blank_q;
    bcnt_d    = bcnt_q;
`endif
    if (wrap) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      clk_out_d = ~clk_out_q;
      dig_d     = dig_nxt;
`ifdef SEG_BLANK_EN
      anode_d   = '1;
      blank_d   = 1'b1;
      bcnt_d    = CNT_W'(BLANK_CYC - 1);
`else
      anode_d   = sel_low(dig_nxt);
`endif
      if (div_load) begin
        div_cur_d = div_clamp;
        shadow_d  = div_clamp;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        div_cur_d = shadow_q;
        pend_d    = 1'b0;
      end
    end else begin
      if (en) begin
        cnt_d = cnt_q + 1'b1;
`ifdef SEG_BLANK_EN
        if (blank_q) begin
          if (bcnt_q == '0) begin
            blank_d = 1'b0;
            anode_d = sel_low(dig_q);
          end else begin
            bcnt_d = bcnt_q - 1'b1;
          end
        end
`endif
      end else if (pend_q) begin
        // idle display: no period to protect, so apply the shadow straight away
        div_cur_d = shadow_q;
        pend_d    = 1'b0;
      end
      if (div_load) begin
        shadow_d = div_clamp;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt_q     <= '0;
      div_cur_q <= CNT_W'(DIV_DEFAULT);
      shadow_q  <= CNT_W'(DIV_DEFAULT);
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      dig_q     <= '0;
      anode_q   <= ~NUM_DIGITS'(1);
`ifdef SEG_BLANK_EN
      blank_q   <= 1'b0;
      bcnt_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      dig_q     <= dig_d;
      anode_q   <= anode_d;
`ifdef SEG_BLANK_EN
      blank_q   <= blank_d;
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  assign div_pending = pend_q;
  assign div_cur     = div_cur_q;
  assign tick        = tick_q;
  assign clk_out     = clk_out_q;
  assign digit_idx   = dig_q;
  assign anode       = anode_q;

endmodule

// File: tb/tb_seg_scan_divider.sv
// Directed bench for seg_scan_divider: divisor 3 at reset, 4 digits, blank length 2.
module tb_seg_scan_divider;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_in = '0;
  logic       div_load = 1'b0;
  logic       div_pending;
  logic [7:0] div_cur;
  logic       tick;
  logic       clk_out;
  logic [1:0] digit_idx;
  logic [3:0] anode;
  logic       blank;

  int checks = 0;
  int errors = 0;
  logic       exp_clk;
  logic [1:0] exp_dig;
  logic       exp_t;
  logic [3:0] exp_an;
  logic [3:0] one = 4'b0001;

`ifdef SEG_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  seg_scan_divider #(
    .CNT_W(8), .DIV_DEFAULT(3), .NUM_DIGITS(4), .DIG_W(2), .BLANK_CYC(2)
  ) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .div_in(div_in), .div_load(div_load),
    .div_pending(div_pending), .div_cur(div_cur), .tick(tick), .clk_out(clk_out),
    .digit_idx(digit_idx), .anode(anode), .blank(blank)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Advance the reference after an expected tick and compare the scan outputs.
  task automatic tick_outputs(input string tag);
    exp_clk = ~exp_clk;
    exp_dig = (exp_dig == 2'd3) ? 2'd0 : exp_dig + 2'd1;
    exp_an  = BLANK_ON ? 4'hF : ~(one << exp_dig);
    checks += 3;
    if (clk_out !== exp_clk) begin errors++; $display("FAIL %s clk_out got %b want %b", tag, clk_out, exp_clk); end
    if (digit_idx !== exp_dig) begin errors++; $display("FAIL %s digit_idx got %0d want %0d", tag, digit_idx, exp_dig); end
    if (anode !== exp_an) begin errors++; $display("FAIL %s anode got %b want %b", tag, anode, exp_an); end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1;
    step(); step();
    checks += 7;
    if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", tick); end
    if (clk_out !== 1'b0) begin errors++; $display("FAIL rst_clk_out got %b want 0", clk_out); end
    if (digit_idx !== 2'd0) begin errors++; $display("FAIL rst_digit got %0d want 0", digit_idx); end
    if (anode !== 4'b1110) begin errors++; $display("FAIL rst_anode got %b want 1110", anode); end
    if (div_cur !== 8'd3) begin errors++; $display("FAIL rst_div_cur got %0d want 3", div_cur); end
    if (div_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", div_pending); end
    if (blank !== 1'b0) begin errors++; $display("FAIL rst_blank got %b want 0", blank); end
    exp_clk = 1'b0; exp_dig = 2'd0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_t = (e % 4 == 0);
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL basic_tick edge %0d got %b want %b", e, tick, exp_t); end
      if (exp_t) tick_outputs("basic");
    end
  endtask

  task automatic test_load();
    step();
    div_in = 8'd5; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks += 3;
    if (div_pending !== 1'b1) begin errors++; $display("FAIL load_pending got %b want 1", div_pending); end
    if (div_cur !== 8'd3) begin errors++; $display("FAIL load_old_div got %0d want 3", div_cur); end
    if (tick !== 1'b0) begin errors++; $display("FAIL load_tick_early got %b want 0", tick); end
    step();
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL load_tick_cnt3 got %b want 0", tick); end
    step();
    checks += 3;
    if (tick !== 1'b1) begin errors++; $display("FAIL load_wrap_tick got %b want 1", tick); end
    if (div_cur !== 8'd5) begin errors++; $display("FAIL load_apply got %0d want 5", div_cur); end
    if (div_pending !== 1'b0) begin errors++; $display("FAIL load_clear got %b want 0", div_pending); end
    tick_outputs("load_wrap");
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_t = (i == 6);
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL load_period cyc %0d got %b want %b", i, tick, exp_t); end
      if (exp_t) tick_outputs("load_period");
    end
  endtask

  task automatic test_load_wrap();
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL lw_pre cyc %0d got %b want 0", i, tick); end
    end
    div_in = 8'd0; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks += 3;
    if (tick !== 1'b1) begin errors++; $display("FAIL lw_tick got %b want 1", tick); end
    if (div_cur !== 8'd1) begin errors++; $display("FAIL lw_clamp got %0d want 1", div_cur); end
    if (div_pending !== 1'b0) begin errors++; $display("FAIL lw_pending got %b want 0", div_pending); end
    tick_outputs("lw_wrap");
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_t = (i % 2 == 0);
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL lw_period2 cyc %0d got %b want %b", i, tick, exp_t); end
      if (exp_t) tick_outputs("lw_period2");
    end
  endtask

  task automatic test_enable();
    div_in = 8'd7; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if (div_pending !== 1'b1) begin errors++; $display("FAIL en_pending got %b want 1", div_pending); end
    step();
    checks += 2;
    if (tick !== 1'b1) begin errors++; $display("FAIL en_apply_tick got %b want 1", tick); end
    if (div_cur !== 8'd7) begin errors++; $display("FAIL en_apply_div got %0d want 7", div_cur); end
    tick_outputs("en_apply");
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL en_pre cyc %0d got %b want 0", i, tick); end
    end
    en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks += 3;
      if (tick !== 1'b0) begin errors++; $display("FAIL en_hold_tick cyc %0d got %b want 0", i, tick); end
      if (clk_out !== exp_clk) begin errors++; $display("FAIL en_hold_clk cyc %0d got %b want %b", i, clk_out, exp_clk); end
      if (digit_idx !== exp_dig) begin errors++; $display("FAIL en_hold_digit cyc %0d got %0d want %0d", i, digit_idx, exp_dig); end
    end
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_t = (i == 5);
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL en_resume cyc %0d got %b want %b", i, tick, exp_t); end
      if (exp_t) tick_outputs("en_resume");
    end
  endtask

  task automatic test_en_apply();
    for (int i = 1; i <= 4; i++) step();
    div_in = 8'd2; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks += 2;
    if (div_pending !== 1'b1) begin errors++; $display("FAIL ea_pending got %b want 1", div_pending); end
    if (div_cur !== 8'd7) begin errors++; $display("FAIL ea_old_div got %0d want 7", div_cur); end
    en = 1'b0;
    step();
    checks += 4;
    if (div_cur !== 8'd2) begin errors++; $display("FAIL ea_idle_apply got %0d want 2", div_cur); end
    if (div_pending !== 1'b0) begin errors++; $display("FAIL ea_idle_clear got %b want 0", div_pending); end
    if (tick !== 1'b0) begin errors++; $display("FAIL ea_idle_tick got %b want 0", tick); end
    if (digit_idx !== exp_dig) begin errors++; $display("FAIL ea_idle_digit got %0d want %0d", digit_idx, exp_dig); end
    en = 1'b1;
    step();
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL ea_below_wrap got %b want 1", tick); end
    tick_outputs("ea_below");
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_t = (i == 3);
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL ea_period3 cyc %0d got %b want %b", i, tick, exp_t); end
      if (exp_t) tick_outputs("ea_period3");
    end
  endtask

  task automatic test_reset_mid();
    step();
    div_in = 8'd9; div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if (div_pending !== 1'b1) begin errors++; $display("FAIL rm_pending_set got %b want 1", div_pending); end
    reset = 1'b0;
    step();
    checks += 6;
    if (div_cur !== 8'd3) begin errors++; $display("FAIL rm_div_cur got %0d want 3", div_cur); end
    if (div_pending !== 1'b0) begin errors++; $display("FAIL rm_pending got %b want 0", div_pending); end
    if (clk_out !== 1'b0) begin errors++; $display("FAIL rm_clk_out got %b want 0", clk_out); end
    if (digit_idx !== 2'd0) begin errors++; $display("FAIL rm_digit got %0d want 0", digit_idx); end
    if (anode !== 4'b1110) begin errors++; $display("FAIL rm_anode got %b want 1110", anode); end
    if (tick !== 1'b0) begin errors++; $display("FAIL rm_tick got %b want 0", tick); end
    reset = 1'b1;
    exp_clk = 1'b0; exp_dig = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_t = (i == 4);
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL rm_first_tick edge %0d got %b want %b", i, tick, exp_t); end
      if (exp_t) tick_outputs("rm_first");
    end
  endtask

`ifdef SEG_BLANK_EN
  task automatic test_blank();
    div_in = 8'd9; div_load = 1'b1;
    step();
    div_load = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (div_cur !== 8'd9) begin errors++; $display("FAIL bl_div got %0d want 9", div_cur); end
    exp_clk = ~exp_clk;
    exp_dig = exp_dig + 2'd1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_t = (i == 10);
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL bl_tick cyc %0d got %b want %b", i, tick, exp_t); end
      if (exp_t) tick_outputs("bl_tick");
    end
    checks++;
    if (blank !== 1'b1) begin errors++; $display("FAIL bl_on0 got %b want 1", blank); end
    step();
    checks += 2;
    if (blank !== 1'b1) begin errors++; $display("FAIL bl_on1 got %b want 1", blank); end
    if (anode !== 4'hF) begin errors++; $display("FAIL bl_anode1 got %b want 1111", anode); end
    step();
    exp_an = ~(one << exp_dig);
    checks += 2;
    if (blank !== 1'b0) begin errors++; $display("FAIL bl_off got %b want 0", blank); end
    if (anode !== exp_an) begin errors++; $display("FAIL bl_anode_restore got %b want %b", anode, exp_an); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_load_wrap();
    test_enable();
    test_en_apply();
    test_reset_mid();
`ifdef SEG_BLANK_EN
    test_blank();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
